// File: rtl/counter_pkg.sv
// Shared counter types and helpers for the lab counter/timer blocks.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } count_mode_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Clamp a load value into 0..limit; 32 bits covers every legal WIDTH.
    function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sync_reg.sv
// Parametrised register with synchronous active-high reset and load enable.
module sync_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap/saturate mode,
// Mealy terminal count for cascading and a sticky boundary flag.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MAX      = (longint'(1) << WIDTH) - 1,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("updown_mod_counter: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
        end
        if (MAX < 0 || MAX > (longint'(1) << WIDTH) - 1) begin : g_bad_max
            $error("updown_mod_counter: MAX %0d does not fit in %0d bits", MAX, WIDTH);
        end
    endgenerate

    localparam logic [WIDTH:0]   MAX_X = MAX[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];
    localparam count_mode_e      MODE  = SATURATE ? MODE_SAT : MODE_WRAP;

    count_dir_e       dir;
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH-1:0] load_w;
    logic [WIDTH-1:0] next_out;
    logic             out_we;
    logic             boundary;

    // Steps run one bit wider so MAX+1 and 0-1 stay distinguishable.
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dir      = up ? DIR_UP : DIR_DOWN;
        cur_x    = {1'b0, out};
        load_w   = WIDTH'(clamp(32'(loadVal), 32'(MAX)));
        step_x   = cur_x;
        boundary = 1'b0;
        next_out = out;
        out_we   = 1'b0;

        if (clr) begin
            next_out = '0;
            out_we   = 1'b1;
        end else if (load) begin
            next_out = load_w;
            out_we   = 1'b1;
        end else if (en) begin
            out_we = 1'b1;
            if (dir == DIR_UP) begin
                step_x   = cur_x + (WIDTH+1)'(1);
                boundary = (step_x > MAX_X);
                if (boundary) begin
                    next_out = (MODE == MODE_SAT) ? MAX_W : '0;
                end else begin
                    next_out = step_x[WIDTH-1:0];
                end
            end else begin
                step_x   = cur_x - (WIDTH+1)'(1);
                boundary = step_x[WIDTH];
                if (boundary) begin
                    next_out = (MODE == MODE_SAT) ? '0 : MAX_W;
                end else begin
                    next_out = step_x[WIDTH-1:0];
                end
            end
        end
    end

    assign tc = boundary & ~rst;

    sync_reg #(.WIDTH(WIDTH)) u_count_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (out_we),
        .d       (next_out),
        .q       (out)
    );

    // Sticky flag: set on any boundary event, cleared only by rst.
    sync_reg #(.WIDTH(1)) u_ovf_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (boundary),
        .d       (1'b1),
        .q       (ovf)
    );

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: directed scenarios plus random traffic on several
// counter configurations, all compared against an arithmetic reference model.
module tb_updown_mod_counter;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       up;
    } ctl_t;

    // 0 decade, 1 sat 0..12, 2 cascade low, 3 cascade high, 4 full 8-bit, 5 sat 0..20
    localparam int N = 6;
    localparam int MAXV [N] = '{9, 12, 9, 9, 255, 20};
    localparam bit SATV [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam int WV   [N] = '{4, 4, 4, 4, 8, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ctl_t       ctl [N];
    logic       tc_v [N];
    logic       ovf_v [N];
    logic [3:0] q_dec, q_sat, q_lo, q_hi;
    logic [7:0] q_rw;
    logic [4:0] q_rs;

    int m_cnt [N];
    bit m_ovf [N];
    int checks = 0;
    int errors = 0;
    int hi_pulses = 0;

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_dec (
        .clk(clk), .rst(ctl[0].rst), .clr(ctl[0].clr), .load(ctl[0].load),
        .loadVal(ctl[0].lv[3:0]), .en(ctl[0].en), .up(ctl[0].up),
        .out(q_dec), .tc(tc_v[0]), .ovf(ovf_v[0]));

    updown_mod_counter #(.WIDTH(4), .MAX(12), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(ctl[1].rst), .clr(ctl[1].clr), .load(ctl[1].load),
        .loadVal(ctl[1].lv[3:0]), .en(ctl[1].en), .up(ctl[1].up),
        .out(q_sat), .tc(tc_v[1]), .ovf(ovf_v[1]));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(ctl[2].rst), .clr(ctl[2].clr), .load(ctl[2].load),
        .loadVal(ctl[2].lv[3:0]), .en(ctl[2].en), .up(ctl[2].up),
        .out(q_lo), .tc(tc_v[2]), .ovf(ovf_v[2]));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(ctl[2].rst), .clr(1'b0), .load(1'b0),
        .loadVal(4'd0), .en(tc_v[2]), .up(ctl[2].up),
        .out(q_hi), .tc(tc_v[3]), .ovf(ovf_v[3]));

    updown_mod_counter #(.WIDTH(8), .SATURATE(1'b0)) u_rw (
        .clk(clk), .rst(ctl[4].rst), .clr(ctl[4].clr), .load(ctl[4].load),
        .loadVal(ctl[4].lv), .en(ctl[4].en), .up(ctl[4].up),
        .out(q_rw), .tc(tc_v[4]), .ovf(ovf_v[4]));

    updown_mod_counter #(.WIDTH(5), .MAX(20), .SATURATE(1'b1)) u_rs (
        .clk(clk), .rst(ctl[5].rst), .clr(ctl[5].clr), .load(ctl[5].load),
        .loadVal(ctl[5].lv[4:0]), .en(ctl[5].en), .up(ctl[5].up),
        .out(q_rs), .tc(tc_v[5]), .ovf(ovf_v[5]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_out(input int i);
        case (i)
            0:       return 64'(q_dec);
            1:       return 64'(q_sat);
            2:       return 64'(q_lo);
            3:       return 64'(q_hi);
            4:       return 64'(q_rw);
            default: return 64'(q_rs);
        endcase
    endfunction

    // Reference model: the counter is a value in 0..mx moved by plain arithmetic.
    function automatic int model_next(input int c, input int mx, input bit sat,
                                      input int w, input ctl_t x);
        int lv;
        lv = int'(x.lv) % (1 << w);
        if (x.rst || x.clr) return 0;
        if (x.load) return (lv > mx) ? mx : lv;
        if (!x.en) return c;
        if (sat) return x.up ? ((c < mx) ? c + 1 : mx) : ((c > 0) ? c - 1 : 0);
        return x.up ? (c + 1) % (mx + 1) : (c + mx) % (mx + 1);
    endfunction

    function automatic bit model_event(input int c, input int mx, input ctl_t x);
        return !x.clr && !x.load && x.en && (x.up ? (c == mx) : (c == 0));
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step();
        ctl_t eff [N];
        bit   ev  [N];
        int   nxt [N];
        eff = ctl;
        for (int i = 0; i < N; i++) begin
            if (i != 3) ev[i] = model_event(m_cnt[i], MAXV[i], eff[i]);
        end
        eff[3] = '{rst: ctl[2].rst, clr: 1'b0, load: 1'b0, lv: 8'd0,
                   en: ev[2] && !ctl[2].rst, up: ctl[2].up};
        ev[3] = model_event(m_cnt[3], MAXV[3], eff[3]);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("tc%0d", i), 64'(tc_v[i]), 64'(ev[i] && !eff[i].rst));
        end
        if (tc_v[3] === 1'b1) hi_pulses++;
        for (int i = 0; i < N; i++) begin
            nxt[i] = model_next(m_cnt[i], MAXV[i], SATV[i], WV[i], eff[i]);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = nxt[i];
            m_ovf[i] = eff[i].rst ? 1'b0 : (m_ovf[i] | ev[i]);
            check($sformatf("out%0d", i), get_out(i), 64'(m_cnt[i]));
            check($sformatf("ovf%0d", i), 64'(ovf_v[i]), 64'(m_ovf[i]));
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) ctl[i] = '{default: '0};
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end

        // Reset everything
        idle_all();
        for (int i = 0; i < N; i++) ctl[i].rst = 1'b1;
        step();
        check("reset_out", 64'(q_dec), 64'd0);
        check("reset_ovf", 64'(ovf_v[0]), 64'd0);

        // Decade up-count through the wrap
        idle_all();
        ctl[0].en = 1'b1; ctl[0].up = 1'b1;
        repeat (9) step();
        check("dec_at9", 64'(q_dec), 64'd9);
        check("dec_tc_at9", 64'(tc_v[0]), 64'd1);
        step();
        check("dec_wrap", 64'(q_dec), 64'd0);
        check("dec_ovf", 64'(ovf_v[0]), 64'd1);

        // Down-wrap from 1
        ctl[0] = '{default: '0}; ctl[0].load = 1'b1; ctl[0].lv = 8'd1;
        step();
        ctl[0] = '{default: '0}; ctl[0].en = 1'b1;
        repeat (3) step();
        check("dec_down", 64'(q_dec), 64'd8);

        // Saturating counter held at MAX
        idle_all();
        ctl[1].load = 1'b1; ctl[1].lv = 8'd11;
        step();
        ctl[1] = '{default: '0}; ctl[1].en = 1'b1; ctl[1].up = 1'b1;
        repeat (3) step();
        check("sat_hold", 64'(q_sat), 64'd12);
        check("sat_tc", 64'(tc_v[1]), 64'd1);
        check("sat_ovf", 64'(ovf_v[1]), 64'd1);

        // Clamp and priority
        idle_all();
        ctl[0].load = 1'b1; ctl[0].lv = 8'd15;
        step();
        check("clamp", 64'(q_dec), 64'd9);
        ctl[0].lv = 8'd3; ctl[0].en = 1'b1; ctl[0].up = 1'b1;
        step();
        check("load_beats_en", 64'(q_dec), 64'd3);
        ctl[0] = '{default: '0}; ctl[0].clr = 1'b1; ctl[0].load = 1'b1; ctl[0].lv = 8'd5;
        step();
        check("clr_beats_load", 64'(q_dec), 64'd0);
        check("clr_keeps_ovf", 64'(ovf_v[0]), 64'd1);

        // Reset mid-operation
        ctl[0] = '{default: '0}; ctl[0].load = 1'b1; ctl[0].lv = 8'd7;
        step();
        check("pre_rst", 64'(q_dec), 64'd7);
        ctl[0] = '{rst: 1'b1, clr: 1'b0, load: 1'b1, lv: 8'd5, en: 1'b1, up: 1'b1};
        step();
        check("rst_out", 64'(q_dec), 64'd0);
        check("rst_ovf", 64'(ovf_v[0]), 64'd0);

        // Two-digit decade cascade
        idle_all();
        ctl[2].en = 1'b1; ctl[2].up = 1'b1;
        hi_pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 99) begin
                check("pair99", 64'(q_hi) * 10 + 64'(q_lo), 64'd99);
                check("hi_tc99", 64'(tc_v[3]), 64'd1);
            end
            step();
        end
        check("pair_wrap", 64'(q_hi) * 10 + 64'(q_lo), 64'd0);
        check("hi_tc_pulses", 64'(hi_pulses), 64'd1);

        // Random traffic on the standalone counters
        idle_all();
        for (int k = 0; k < 400; k++) begin
            foreach (ctl[i]) begin
                if (i == 2 || i == 3) continue;
                ctl[i].rst  = ($urandom_range(0, 31) == 0);
                ctl[i].clr  = ($urandom_range(0, 15) == 0);
                ctl[i].load = ($urandom_range(0, 7) == 0);
                ctl[i].lv   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                ctl[i].en   = ($urandom_range(0, 3) != 0);
                ctl[i].up   = 1'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter with synchronous load, clear, enable, wrap or saturate mode, and cascadable terminal-count output. All state bits change on a single clock edge, with no rippled clocks. It is the general-purpose counter for the lab designs: decade counters for display digits, event counters, and timeout timers. Several instances chain through `tc` → `en` to form multi-digit counters.

## Interface
- `WIDTH`, default 8: counter register width in bits; legal range 2..32.
- `MAX`, default 2**WIDTH-1: highest count value. The counter range is 0..MAX, and MAX must be ≤ 2**WIDTH-1.
- `SATURATE`, default 0: 0 = wrap at boundaries; 1 = hold at boundaries.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `clr` in 1: synchronous clear to 0; does not clear `ovf`.
- `load` in 1: synchronous parallel load of `loadVal`.
- `loadVal` in WIDTH: value to load.
- `en` in 1: count enable.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `out` out WIDTH: current count.
- `tc` out 1: terminal count, combinational (Mealy). It is high when the next edge would step past a boundary.
- `ovf` out 1: sticky boundary-event flag, registered.

## Operation
- Priority at each rising edge is `rst` > `clr` > `load` > `en`. Lower-priority inputs are ignored in that cycle.
- `rst` = 1 sets `out` = 0 and `ovf` = 0.
- `clr` = 1 sets `out` = 0; `ovf` is unchanged.
- `load` = 1 sets `out` = min(`loadVal`, MAX), so out-of-range load values clamp to MAX.
- `en` = 1, `up` = 1:
  - If `out` < MAX, `out` + 1.
  - If `out` = MAX, the next value is 0 (SATURATE = 0) or MAX (SATURATE = 1).
- `en` = 1, `up` = 0:
  - If `out` > 0, `out` − 1.
  - If `out` = 0, the next value is MAX (SATURATE = 0) or 0 (SATURATE = 1).
- `en` = 0 with no higher-priority input: `out` holds.
- Boundary event: `en` = 1 and not (`rst` | `clr` | `load`), with either `up` = 1 and `out` = MAX, or `up` = 0 and `out` = 0.
- `tc` = the boundary event, evaluated combinationally from the current `out` and inputs. It is forced to 0 while `rst` is high.
- `ovf` is set at the edge where a boundary event occurs, in both modes. It stays set until `rst`.
- `out` never leaves 0..MAX, regardless of input sequence.
- Arithmetic is done in WIDTH+1 bits internally, so increment or decrement at 2**WIDTH-1 or 0 cannot alias before the boundary compare.

## Timing
- Latency: every input change is reflected in `out` and `ovf` one edge later. `tc` responds in the same cycle, combinationally.
- Reset values: `out` = 0, `ovf` = 0, `tc` = 0.
- Reset mid-count: the first edge with `rst` high zeroes `out` and `ovf` regardless of `load`, `en` and `clr`.
- Simultaneous `load` and `en`: the load wins. No step is applied and `tc` = 0.
- Direction may change every cycle. There is no turnaround penalty.
- Cascading: the low digit's `tc` drives the next digit's `en`, with a shared `up`. The carry or borrow advances the next digit on the same edge the low digit wraps. A cascade of N digits has a combinational `tc` path through N stages, and the integrator must time-close it.

## Structure
- Shared package `counter_pkg` holds:
  - typedef `count_dir_e` {`DIR_DOWN` = 0, `DIR_UP` = 1};
  - typedef `count_mode_e` {`MODE_WRAP`, `MODE_SAT`};
  - a `function automatic clamp` for load values, shared with future timer blocks.
- Sub-module `sync_reg`: a parametrised WIDTH-bit register with synchronous active-high reset and a load enable. It holds `out`; a 1-bit instance holds `ovf`.
- Next-state and `tc` logic live in `updown_mod_counter` as one combinational block.
- Parameter checks run at elaboration:
  - MAX ≤ 2**WIDTH-1, else `$error`;
  - WIDTH in 2..32.

## Test plan
- Decade wrap (WIDTH = 4, MAX = 9, SATURATE = 0):
  - reset, then 10 cycles of `en` = 1, `up` = 1 → `out` goes 0..9 then 0.
  - `tc` is high only in the cycle where `out` = 9.
  - `ovf` = 1 after the wrap.
- Down wrap, same config: `load` with `loadVal` = 1, then `en` = 1, `up` = 0 for 3 cycles → `out` goes 1, 0, 9, 8; `tc` is high while `out` = 0.
- Saturate (WIDTH = 4, MAX = 12, SATURATE = 1): load 11, count up 3 cycles → `out` goes 11, 12, 12, 12; `tc` stays high while `out` = 12; `ovf` = 1.
- Clamp and priority (MAX = 9):
  - load `loadVal` = 15 → `out` = 9.
  - assert `load` (`loadVal` = 3), `en`, `up` together → `out` = 3, `tc` = 0.
  - assert `clr` together with `load` → `out` = 0, `ovf` unchanged.
- Reset mid-operation: at `out` = 7 with `ovf` = 1, assert `rst` together with `load` and `en` for one cycle → `out` = 0, `ovf` = 0, `tc` = 0 during `rst`.
- Cascade: two decade instances, the low digit's `tc` drives the high digit's `en`, 100 up-count cycles → the pair reads 00..99 then 00. The high digit's `tc` pulses exactly once, in the cycle where the pair reads 99.
